// File: rtl/serial_word_comp_if.sv
// serial_word_comp_if
//   Groups the serial compare stream and its framed result bus.
//   master : drives start/abort/bit_valid/i0/i1, observes status and results
//   slave  : the comparator; consumes the stream, drives status and results
//   Ports carried:
//     start, abort, bit_valid, i0, i1          (master -> slave)
//     busy, done, eq, mismatch_cnt,
//     first_mis_idx, first_mis_vld             (slave -> master)
interface serial_word_comp_if #(
  parameter int N = 8
) ();
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic          start;
  logic          abort;
  logic          bit_valid;
  logic          i0;
  logic          i1;
  logic          busy;
  logic          done;
  logic          eq;
  logic [CW-1:0] mismatch_cnt;
  logic [IW-1:0] first_mis_idx;
  logic          first_mis_vld;

  modport master (
    output start, abort, bit_valid, i0, i1,
    input  busy, done, eq, mismatch_cnt, first_mis_idx, first_mis_vld
  );

  modport slave (
    input  start, abort, bit_valid, i0, i1,
    output busy, done, eq, mismatch_cnt, first_mis_idx, first_mis_vld
  );
endinterface

// File: rtl/serial_word_comp.sv
// serial_word_comp
//   Bit-serial N-bit word equality comparator. Two LSB-first bit streams are
//   compared pair by pair with the gate-level equality function; across a
//   framed word it counts mismatching pairs and remembers the index of the
//   first one. At end of frame it publishes eq / mismatch_cnt /
//   first_mis_idx / first_mis_vld and pulses done for one cycle.
//   Ports:
//     clk      : single clock, rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : serial_word_comp_if.slave (stream in, status/results out)
module serial_word_comp #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  serial_word_comp_if.slave   bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q,     state_d;
  logic [IW-1:0] idx_q,       idx_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          mis_flag_q,  mis_flag_d;
  logic [IW-1:0] mis_idx_q,   mis_idx_d;
  logic          eq_q,        eq_d;
  logic [CW-1:0] res_cnt_q,   res_cnt_d;
  logic [IW-1:0] res_idx_q,   res_idx_d;
  logic          res_vld_q,   res_vld_d;

  logic bit_eq;

  // Gate-level 1-bit equality.
  always_comb begin
    bit_eq = (bus.i0 & bus.i1) | (~bus.i0 & ~bus.i1);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    mis_flag_d = mis_flag_q;
    mis_idx_d  = mis_idx_q;
    eq_d       = eq_q;
    res_cnt_d  = res_cnt_q;
    res_idx_d  = res_idx_q;
    res_vld_d  = res_vld_q;

    case (state_q)
      S_IDLE: begin
        // A bit presented together with start is not part of the frame.
        if (bus.start && !bus.abort) begin
          state_d    = S_RUN;
          idx_d      = '0;
          cnt_d      = '0;
          mis_flag_d = 1'b0;
          mis_idx_d  = '0;
        end
      end

      S_RUN: begin
        // Abort wins over a bit in the same cycle; published results stay.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.bit_valid) begin
          if (!bit_eq) begin
            cnt_d = cnt_q + CW'(1);
            if (!mis_flag_q) begin
              mis_flag_d = 1'b1;
              mis_idx_d  = idx_q;
            end
          end
          if (idx_q == IW'(N - 1)) begin
            // Last bit: publish using the updated running values so this
            // bit is included in the result.
            state_d   = S_DONE;
            eq_d      = (cnt_d == '0);
            res_cnt_d = cnt_d;
            res_idx_d = mis_idx_d;
            res_vld_d = mis_flag_d;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      mis_flag_q <= 1'b0;
      mis_idx_q  <= '0;
      eq_q       <= 1'b0;
      res_cnt_q  <= '0;
      res_idx_q  <= '0;
      res_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      mis_flag_q <= mis_flag_d;
      mis_idx_q  <= mis_idx_d;
      eq_q       <= eq_d;
      res_cnt_q  <= res_cnt_d;
      res_idx_q  <= res_idx_d;
      res_vld_q  <= res_vld_d;
    end
  end

  assign bus.busy          = (state_q == S_RUN);
  assign bus.done          = (state_q == S_DONE);
  assign bus.eq            = eq_q;
  assign bus.mismatch_cnt  = res_cnt_q;
  assign bus.first_mis_idx = res_idx_q;
  assign bus.first_mis_vld = res_vld_q;
endmodule

// File: doc/serial_word_comp.md
# serial_word_comp

Bit-serial N-bit word equality comparator: consumes two serial bit streams one bit per valid cycle, applies the gate-level 1-bit equality function (eq = i0·i1 + ~i0·~i1) to each bit pair, and accumulates across a framed word. At end of frame it reports word equality, mismatch count and the index of the first mismatching bit. It sits directly downstream of the bit-level comparator logic and upstream of any control logic that needs a per-word compare result.

## Interface
- N, 8, word length in bits (N ≥ 2)
- IW, $clog2(N), width of bit index
- CW, $clog2(N+1), width of mismatch counter
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request new frame; accepted only in IDLE
- abort  in  1  cancel frame in progress
- bit_valid  in  1  i0/i1 carry a valid bit pair this cycle
- i0  in  1  serial bit, stream A (LSB first)
- i1  in  1  serial bit, stream B (LSB first)
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse: results updated
- eq  out  1  last completed frame: all N bit pairs equal
- mismatch_cnt  out  CW  last completed frame: number of unequal bit pairs (0..N)
- first_mis_idx  out  IW  last completed frame: index of first unequal pair (0 if none)
- first_mis_vld  out  1  last completed frame: at least one mismatch

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 and abort=0 → RUN; clear internal bit index, running count, first-mismatch flag/index. Otherwise stay.
- RUN: on each bit_valid=1 cycle, bit_eq = (i0 & i1) | (~i0 & ~i1); if bit_eq=0: count += 1, and if no mismatch recorded yet, record current index and set flag. Index increments by 1.
- RUN: bit_valid=1 with index = N-1 → DONE (that bit is included). bit_valid=0 → hold, no update (gaps allowed, unbounded).
- RUN: abort=1 → IDLE; bit in that cycle discarded; no done; outputs keep prior frame results. abort beats bit_valid.
- DONE: lasts exactly one cycle, then → IDLE unconditionally. start in DONE ignored.
- Output registers (eq, mismatch_cnt, first_mis_idx, first_mis_vld) load on the transition RUN→DONE and hold until the next such transition. eq = (final count == 0).
- start while busy ignored; bit_valid in IDLE or DONE ignored; bit_valid in the cycle start is accepted ignored.
- Counter width: count saturates naturally at N ≤ 2^CW−1; no wrap possible. Index never exceeds N-1.

## Timing
- Reset (reset_n=0, async): state=IDLE; busy=0, done=0, eq=0, mismatch_cnt=0, first_mis_idx=0, first_mis_vld=0; internal index/count/flag=0. Reset mid-frame discards frame.
- start sampled at edge k → busy=1 after edge k; first bit sampled at edge k+1 earliest.
- Last bit sampled at edge m → done=1 and new results visible after edge m; busy=0 after edge m.
- Minimum frame: start edge + N bit edges + 1 DONE cycle; next start accepted at edge m+2 (IDLE). Back-to-back throughput: N+2 cycles per word.
- busy and done never high simultaneously; done never high on two consecutive cycles.

## Test plan
- Reset: reset_n low mid-RUN after 3 bits → all outputs 0 immediately (async), state IDLE; subsequent start works normally.
- Equal words, N=8: A=B=8'hA5, bit_valid continuous → done one cycle after 8th bit; eq=1, mismatch_cnt=0, first_mis_vld=0, first_mis_idx=0.
- Mismatches: A=8'hA5, B=8'hA4^8'h40 (=8'hE4) → bits 0 and 6 differ: eq=0, mismatch_cnt=2, first_mis_idx=0, first_mis_vld=1; A=8'h00,B=8'hFF → mismatch_cnt=8, first_mis_idx=0.
- Gapped input: A=8'h0F, B=8'h1F with bit_valid toggling 1/0 and random stalls → eq=0, mismatch_cnt=1, first_mis_idx=4; done exactly once, after 8th valid bit.
- Abort: prior result eq=1; start, 5 bits with a mismatch at idx 2, abort=1 with bit_valid=1 → IDLE, no done, outputs still eq=1, cnt=0; start+abort same cycle in IDLE → stays IDLE.
- Ignored controls: start asserted during RUN and DONE, bit_valid asserted in IDLE and on start-accept cycle → no effect on count/index; back-to-back frames with start at edge m+2 produce correct independent results.
